// File: rtl/cpu_pkg.sv
// Shared types and widths for the 8-bit accumulator core: opcodes, sequencer states, word sizes.
package cpu_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned WORD_W  = 8;
    localparam int unsigned STATE_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_BNE   = 3'b100,
        OP_JMP   = 3'b101,
        OP_NOP   = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    typedef enum logic [STATE_W-1:0] {
        S_RESET  = 4'd0,
        S_FETCH0 = 4'd1,
        S_FETCH1 = 4'd2,
        S_FETCH2 = 4'd3,
        S_DECODE = 4'd4,
        S_MEMRD  = 4'd5,
        S_EXEC   = 4'd6,
        S_WR1    = 4'd7,
        S_WR2    = 4'd8,
        S_HALT   = 4'd9
    } seq_state_t;

endpackage

// File: rtl/cpu_sequencer.sv
// Control-unit FSM: sequences fetch/decode/execute over sysbus and drives all datapath strobes.
// Outputs are decoded from the state so that reset clears them immediately.
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic            clock,
    input  logic            n_reset,
    input  logic [OP_W-1:0] op,
    input  logic            z_flag,
    input  logic            mem_ready,
    output logic            ACC_bus,
    output logic            PC_bus,
    output logic            MDR_bus,
    output logic            Addr_bus,
    output logic            load_ACC,
    output logic            load_PC,
    output logic            load_IR,
    output logic            load_MAR,
    output logic            load_MDR,
    output logic            INC_PC,
    output logic            ALU_ACC,
    output logic            ALU_add,
    output logic            ALU_sub,
    output logic            CS,
    output logic            R_NW,
    output logic            halted
);

    seq_state_t r_state;
    seq_state_t w_next_state;
    opcode_t    w_op;

    assign w_op = opcode_t'(op);

    // State register
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next_state = S_RESET;
        ACC_bus      = 1'b0;
        PC_bus       = 1'b0;
        MDR_bus      = 1'b0;
        Addr_bus     = 1'b0;
        load_ACC     = 1'b0;
        load_PC      = 1'b0;
        load_IR      = 1'b0;
        load_MAR     = 1'b0;
        load_MDR     = 1'b0;
        INC_PC       = 1'b0;
        ALU_ACC      = 1'b0;
        ALU_add      = 1'b0;
        ALU_sub      = 1'b0;
        CS           = 1'b0;
        R_NW         = 1'b0;
        halted       = 1'b0;

        case (r_state)
            S_RESET: begin
                w_next_state = S_FETCH0;
            end
            S_FETCH0: begin
                PC_bus       = 1'b1;
                load_MAR     = 1'b1;
                INC_PC       = 1'b1;
                w_next_state = S_FETCH1;
            end
            S_FETCH1: begin
                CS           = 1'b1;
                R_NW         = 1'b1;
                load_MDR     = 1'b1;
                w_next_state = mem_ready ? S_FETCH2 : S_FETCH1;
            end
            S_FETCH2: begin
                MDR_bus      = 1'b1;
                load_IR      = 1'b1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                Addr_bus = 1'b1;
                case (w_op)
                    OP_LOAD, OP_ADD, OP_SUB: begin
                        load_MAR     = 1'b1;
                        w_next_state = S_MEMRD;
                    end
                    OP_STORE: begin
                        load_MAR     = 1'b1;
                        w_next_state = S_WR1;
                    end
                    OP_BNE: begin
                        load_PC      = ~z_flag;
                        w_next_state = S_FETCH0;
                    end
                    OP_JMP: begin
                        load_PC      = 1'b1;
                        w_next_state = S_FETCH0;
                    end
                    OP_HALT: begin
                        w_next_state = S_HALT;
                    end
                    default: begin
                        w_next_state = S_FETCH0;
                    end
                endcase
            end
            S_MEMRD: begin
                CS           = 1'b1;
                R_NW         = 1'b1;
                load_MDR     = 1'b1;
                w_next_state = mem_ready ? S_EXEC : S_MEMRD;
            end
            S_EXEC: begin
                MDR_bus      = 1'b1;
                load_ACC     = 1'b1;
                ALU_ACC      = (w_op == OP_ADD) || (w_op == OP_SUB);
                ALU_add      = (w_op == OP_ADD);
                ALU_sub      = (w_op == OP_SUB);
                w_next_state = S_FETCH0;
            end
            S_WR1: begin
                ACC_bus      = 1'b1;
                load_MDR     = 1'b1;
                w_next_state = S_WR2;
            end
            S_WR2: begin
                CS           = 1'b1;
                w_next_state = mem_ready ? S_FETCH0 : S_WR2;
            end
            S_HALT: begin
                halted       = 1'b1;
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: random instruction stream against a per-instruction cycle-list model.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    localparam logic [15:0] B_ACC_BUS  = 16'h8000;
    localparam logic [15:0] B_PC_BUS   = 16'h4000;
    localparam logic [15:0] B_MDR_BUS  = 16'h2000;
    localparam logic [15:0] B_ADDR_BUS = 16'h1000;
    localparam logic [15:0] B_LD_ACC   = 16'h0800;
    localparam logic [15:0] B_LD_PC    = 16'h0400;
    localparam logic [15:0] B_LD_IR    = 16'h0200;
    localparam logic [15:0] B_LD_MAR   = 16'h0100;
    localparam logic [15:0] B_LD_MDR   = 16'h0080;
    localparam logic [15:0] B_INC_PC   = 16'h0040;
    localparam logic [15:0] B_ALU_ACC  = 16'h0020;
    localparam logic [15:0] B_ALU_ADD  = 16'h0010;
    localparam logic [15:0] B_ALU_SUB  = 16'h0008;
    localparam logic [15:0] B_CS       = 16'h0004;
    localparam logic [15:0] B_R_NW     = 16'h0002;
    localparam logic [15:0] B_HALTED   = 16'h0001;

    localparam logic [15:0] V_FETCH0 = B_PC_BUS | B_LD_MAR | B_INC_PC;
    localparam logic [15:0] V_MEMRD  = B_CS | B_R_NW | B_LD_MDR;
    localparam logic [15:0] V_FETCH2 = B_MDR_BUS | B_LD_IR;
    localparam logic [15:0] V_WR1    = B_ACC_BUS | B_LD_MDR;
    localparam logic [15:0] V_WR2    = B_CS;

    logic            clock;
    logic            n_reset;
    logic [OP_W-1:0] op;
    logic            z_flag;
    logic            mem_ready;
    logic            ACC_bus, PC_bus, MDR_bus, Addr_bus;
    logic            load_ACC, load_PC, load_IR, load_MAR, load_MDR;
    logic            INC_PC, ALU_ACC, ALU_add, ALU_sub, CS, R_NW, halted;
    logic [15:0]     w_obs;

    int n_vec = 0;
    int n_err = 0;

    cpu_sequencer dut (
        .clock     (clock),
        .n_reset   (n_reset),
        .op        (op),
        .z_flag    (z_flag),
        .mem_ready (mem_ready),
        .ACC_bus   (ACC_bus),
        .PC_bus    (PC_bus),
        .MDR_bus   (MDR_bus),
        .Addr_bus  (Addr_bus),
        .load_ACC  (load_ACC),
        .load_PC   (load_PC),
        .load_IR   (load_IR),
        .load_MAR  (load_MAR),
        .load_MDR  (load_MDR),
        .INC_PC    (INC_PC),
        .ALU_ACC   (ALU_ACC),
        .ALU_add   (ALU_add),
        .ALU_sub   (ALU_sub),
        .CS        (CS),
        .R_NW      (R_NW),
        .halted    (halted)
    );

    assign w_obs = {ACC_bus, PC_bus, MDR_bus, Addr_bus, load_ACC, load_PC, load_IR, load_MAR,
                    load_MDR, INC_PC, ALU_ACC, ALU_add, ALU_sub, CS, R_NW, halted};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected $finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected strobes for DECODE and EXEC, straight from the opcode rules
    function automatic logic [15:0] decode_vec(input logic [2:0] o, input logic z);
        logic [15:0] v;
        v = B_ADDR_BUS;
        if (o == OP_LOAD || o == OP_STORE || o == OP_ADD || o == OP_SUB) v = v | B_LD_MAR;
        if (o == OP_JMP || (o == OP_BNE && !z)) v = v | B_LD_PC;
        return v;
    endfunction

    function automatic logic [15:0] exec_vec(input logic [2:0] o);
        logic [15:0] v;
        v = B_MDR_BUS | B_LD_ACC;
        if (o == OP_ADD) v = v | B_ALU_ACC | B_ALU_ADD;
        if (o == OP_SUB) v = v | B_ALU_ACC | B_ALU_SUB;
        return v;
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, advance past the next edge
    task automatic step(input string tag, input logic [15:0] exp, input bit use_rdy, input bit rdy);
        mem_ready = use_rdy ? rdy : 1'($urandom_range(0, 1));
        #1;
        check_val(tag, w_obs, exp);
        check_val("bus_onehot", 16'($countones(w_obs[15:12]) > 1), 16'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic mem_phase(input string tag, input logic [15:0] v, input int stalls);
        for (int i = 0; i < stalls; i++) step(tag, v, 1'b1, 1'b0);
        step(tag, v, 1'b1, 1'b1);
    endtask

    // One instruction; entered at the start of its FETCH0 cycle
    task automatic run_instr(input logic [2:0] o, input logic z, input int sf, input int sm, input int sw);
        op     = o;
        z_flag = z;
        step("fetch0", V_FETCH0, 1'b0, 1'b0);
        mem_phase("fetch1", V_MEMRD, sf);
        step("fetch2", V_FETCH2, 1'b0, 1'b0);
        step("decode", decode_vec(o, z), 1'b0, 1'b0);
        if (o == OP_LOAD || o == OP_ADD || o == OP_SUB) begin
            mem_phase("memrd", V_MEMRD, sm);
            step("exec", exec_vec(o), 1'b0, 1'b0);
        end else if (o == OP_STORE) begin
            step("wr1", V_WR1, 1'b0, 1'b0);
            mem_phase("wr2", V_WR2, sw);
        end
    endtask

    initial begin
        n_reset   = 1'b0;
        op        = 3'b000;
        z_flag    = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_val("reset_init", w_obs, 16'h0000);
        n_reset = 1'b1;
        @(posedge clock);
        #1;

        // Reset asserted while stalled in FETCH1, held for three cycles
        op = OP_LOAD;
        step("fetch0", V_FETCH0, 1'b0, 1'b0);
        step("fetch1", V_MEMRD, 1'b1, 1'b0);
        n_reset = 1'b0;
        #1;
        check_val("reset_async", w_obs, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            check_val("reset_hold", w_obs, 16'h0000);
        end
        n_reset = 1'b1;
        @(posedge clock);
        #1;

        run_instr(OP_ADD,   1'b0, 0, 0, 0);
        run_instr(OP_STORE, 1'b1, 0, 0, 2);
        run_instr(OP_BNE,   1'b0, 0, 0, 0);
        run_instr(OP_BNE,   1'b1, 0, 0, 0);
        run_instr(OP_LOAD,  1'b0, 1, 2, 0);
        run_instr(OP_SUB,   1'b1, 0, 1, 0);
        run_instr(OP_JMP,   1'b1, 2, 0, 0);
        run_instr(OP_NOP,   1'b0, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            run_instr(3'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        // HALT is terminal regardless of inputs until reset
        run_instr(OP_HALT, 1'b0, 1, 0, 0);
        for (int i = 0; i < 25; i++) begin
            op     = 3'($urandom_range(0, 7));
            z_flag = 1'($urandom_range(0, 1));
            step("halt", B_HALTED, 1'b0, 1'b0);
        end
        n_reset = 1'b0;
        #1;
        check_val("halt_reset", w_obs, 16'h0000);
        @(posedge clock);
        #1;
        n_reset = 1'b1;
        @(posedge clock);
        #1;
        run_instr(OP_NOP, 1'b0, 0, 0, 0);
        run_instr(OP_ADD, 1'b1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
